spi_slave_frontend: RTL and testbench
=====================================

Name: spi_slave_frontend

Overview:
- Clock-domain SPI slave engine (mode 0, MSB first) that sits directly upstream of the command decode / register stage of design_main.
- Oversamples the asynchronous SPI pins with clk and deserialises 8-bit command frames (spi_cs_cmd) and 16-bit data frames (spi_cs_data) into single-cycle valid pulses.
- Serialises a 16-bit response word onto spi_sdo during data frames.

Parameters:
- WIDTH_CMD, 8, command frame length in bits
- WIDTH_DATA, 16, data frame length in bits
- SYNC_STAGES, 2, synchroniser flops on each SPI input (min 2)

Ports:
- clk  input  1  system clock (50 MHz nominal)
- rst_n  input  1  reset; asynchronous, active-low
- spi_scl  input  1  SPI clock from master, async to clk
- spi_sdi  input  1  master-out serial data
- spi_cs_cmd  input  1  active-low select, command frame
- spi_cs_data  input  1  active-low select, data frame (write or read)
- spi_sdo  output  1  slave-out serial data
- tx_data  input  WIDTH_DATA  response word from downstream; sampled while spi_cs_data is idle
- cmd_valid  output  1  1-cycle pulse, cmd_word valid
- cmd_word  output  WIDTH_CMD  last complete command
- data_valid  output  1  1-cycle pulse, data_word valid
- data_word  output  WIDTH_DATA  last complete data word
- frame_err  output  1  1-cycle pulse, malformed frame discarded

Behaviour:
- Reset values (async assert, sync release): all outputs 0, all shift registers 0, bit counter 0, state IDLE, synchroniser chains preset to idle levels (scl=0, cs=1, sdi=0).
- Synchronisation: spi_scl, spi_sdi, spi_cs_cmd and spi_cs_data each pass through SYNC_STAGES flops plus one history flop.
  - scl_rise = sync & ~hist; cs_fall and cs_rise are derived the same way.
  - spi_sdi uses the same depth, so it stays aligned with scl_rise.
- Receive: on scl_rise with a CS asserted, shift synced sdi into rx_shift LSB and increment bit_cnt.
  - bit_cnt saturates at WIDTH_DATA+1.
  - scl edges are ignored when no CS is asserted.
- States: IDLE, CMD, DATA, ERR.
  - IDLE -> CMD on cs_cmd low with cs_data high.
  - IDLE -> DATA on cs_data low with cs_cmd high.
  - IDLE -> ERR if both are low.
  - CMD/DATA -> ERR if the other CS asserts mid-frame.
  - CMD/DATA/ERR -> IDLE when both CS are high.
  - Entering CMD or DATA clears bit_cnt and rx_shift.
- Frame end, on the cycle both CS are seen high:
  - CMD with bit_cnt == WIDTH_CMD: cmd_word <= rx_shift[WIDTH_CMD-1:0], cmd_valid = 1 for exactly one clk.
  - DATA with bit_cnt == WIDTH_DATA: data_word <= rx_shift, data_valid = 1 for exactly one clk.
  - Any other count, or leaving ERR: frame_err = 1 for one clk, with no valid pulse and no change to cmd_word/data_word.
- Latency: valid pulse lands SYNC_STAGES+1 clk after the raw CS rising edge.
- Transmit:
  - While spi_cs_data is idle (state != DATA), tx_shift <= tx_data every clk.
  - spi_sdo = tx_shift MSB combinationally, so bit 15 is already present when CS falls; no wait for CS detection.
  - In DATA, on each scl_rise (after the master has sampled), tx_shift shifts left, filling 0.
  - spi_sdo is also driven during CMD frames and idle; it is not tri-stated.
- Timing requirement: SCL half-period ≥ (SYNC_STAGES+2) clk periods, i.e. 80 ns at the defaults.
  - Master samples spi_sdo at its SCL rising edge and changes spi_sdi while SCL is low.
- A read frame also captures master sdi into data_word; the downstream stage qualifies it by the preceding command.
- Reset asserted mid-frame: immediate return to the reset state. The partial frame produces no pulse, including frame_err, after release. A CS still low at release is treated as a new frame start (cs_fall seen from the preset idle level).

Test Plan:
- Command write: CS_cmd frame of 0x80, SCL half-period 100 ns -> one cmd_valid pulse, cmd_word = 0x80, no frame_err.
- Data write: CS_data frame of 0xA5C3 -> one data_valid pulse, data_word = 0xA5C3; then cmd 0x01 followed by data 0xFFFF -> cmd_word 0x01, data_word 0xFFFF, in order.
- Read: tx_data = 0x1234 held, master clocks 16 bits sampling sdo at each rise -> captured 0x1234; repeat with 0xFFFF and 0x0001 -> exact match.
- Short and long frames: 7-bit command -> frame_err pulse, cmd_word unchanged; 17-bit data frame -> frame_err, data_word unchanged.
- Both CS low: assert cs_data during a command frame -> frame_err only after both CS release; next valid frame is accepted normally.
- Reset mid-frame: drop rst_n after 5 data bits -> all outputs 0 immediately; after release, a complete 0x00FF frame -> data_word = 0x00FF, no spurious pulses.

Source files
------------

// File: rtl/spi_slave_frontend.sv
// rtl/spi_slave_frontend.sv - mode-0 SPI slave front end with command/data deframing and response serialiser
//
// Purpose:
//   Oversamples the asynchronous SPI pins with clk. It turns 8-bit command
//   frames (spi_cs_cmd) and 16-bit data frames (spi_cs_data) into single-cycle
//   valid pulses. During data frames it shifts a 16-bit response word out on
//   spi_sdo, MSB first.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   spi_scl      SPI clock from master (async)
//   spi_sdi      master-out serial data (async)
//   spi_cs_cmd   active-low select for command frames (async)
//   spi_cs_data  active-low select for data frames (async)
//   spi_sdo      slave-out serial data, always driven
//   tx_data      response word, loaded while no data frame is in progress
//   cmd_valid    1-cycle pulse, cmd_word updated
//   cmd_word     last complete command
//   data_valid   1-cycle pulse, data_word updated
//   data_word    last complete data word
//   frame_err    1-cycle pulse, malformed frame discarded

module spi_slave_frontend #(
   parameter int WIDTH_CMD   = 8,
   parameter int WIDTH_DATA  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  spi_scl,
   input  logic                  spi_sdi,
   input  logic                  spi_cs_cmd,
   input  logic                  spi_cs_data,
   output logic                  spi_sdo,
   input  logic [WIDTH_DATA-1:0] tx_data,
   output logic                  cmd_valid,
   output logic [WIDTH_CMD-1:0]  cmd_word,
   output logic                  data_valid,
   output logic [WIDTH_DATA-1:0] data_word,
   output logic                  frame_err
);

   localparam int CNT_W = $clog2(WIDTH_DATA + 2);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH_DATA + 1);
   localparam logic [CNT_W-1:0] CNT_CMD  = CNT_W'(WIDTH_CMD);
   localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(WIDTH_DATA);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      DATA = 2'd2,
      ERR  = 2'd3
   } state_t;

   // Synchroniser chains. Index SYNC_STAGES-1 is the synchronised level and
   // index SYNC_STAGES is the history flop used for edge detection.
   logic [SYNC_STAGES:0]   scl_pipe;
   logic [SYNC_STAGES:0]   csc_pipe;
   logic [SYNC_STAGES:0]   csd_pipe;
   // sdi needs no history. Its synchronised level is taken from the same
   // stage as scl, so the bit shifted on scl_rise is the one the master
   // presented at its rising edge.
   logic [SYNC_STAGES-1:0] sdi_pipe;

   logic scl_s, scl_rise;
   logic csc_s, csc_fall;
   logic csd_s, csd_fall;
   logic sdi_s;
   logic both_idle;

   state_t                 state;
   logic [CNT_W-1:0]       bit_cnt;
   logic [WIDTH_DATA-1:0]  rx_shift;
   logic [WIDTH_DATA-1:0]  tx_shift;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_pipe <= '0;
         sdi_pipe <= '0;
         csc_pipe <= '1;
         csd_pipe <= '1;
      end else begin
         scl_pipe <= {scl_pipe[SYNC_STAGES-1:0], spi_scl};
         sdi_pipe <= {sdi_pipe[SYNC_STAGES-2:0], spi_sdi};
         csc_pipe <= {csc_pipe[SYNC_STAGES-1:0], spi_cs_cmd};
         csd_pipe <= {csd_pipe[SYNC_STAGES-1:0], spi_cs_data};
      end
   end

   assign scl_s     = scl_pipe[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_pipe[SYNC_STAGES];
   assign csc_s     = csc_pipe[SYNC_STAGES-1];
   assign csc_fall  = ~csc_s & csc_pipe[SYNC_STAGES];
   assign csd_s     = csd_pipe[SYNC_STAGES-1];
   assign csd_fall  = ~csd_s & csd_pipe[SYNC_STAGES];
   assign sdi_s     = sdi_pipe[SYNC_STAGES-1];
   assign both_idle = csc_s & csd_s;

   // Combinational from the shift register, so the response MSB is already
   // on the pin when the master drops CS.
   assign spi_sdo = tx_shift[WIDTH_DATA-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         rx_shift   <= '0;
         tx_shift   <= '0;
         cmd_valid  <= 1'b0;
         cmd_word   <= '0;
         data_valid <= 1'b0;
         data_word  <= '0;
         frame_err  <= 1'b0;
      end else begin
         cmd_valid  <= 1'b0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;

         // Keep the response word tracking tx_data until a data frame owns it.
         if (state != DATA) begin
            tx_shift <= tx_data;
         end

         case (state)
            IDLE: begin
               // A fall is needed to start a frame. The chains preset to the
               // idle level, so a CS still low at reset release also counts.
               if (csc_fall || csd_fall) begin
                  if (!csc_s && !csd_s) begin
                     state <= ERR;
                  end else if (!csc_s) begin
                     state    <= CMD;
                     bit_cnt  <= '0;
                     rx_shift <= '0;
                  end else if (!csd_s) begin
                     state    <= DATA;
                     bit_cnt  <= '0;
                     rx_shift <= '0;
                  end
               end
            end

            CMD, DATA: begin
               if (both_idle) begin
                  state <= IDLE;
                  if (state == CMD && bit_cnt == CNT_CMD) begin
                     cmd_word  <= rx_shift[WIDTH_CMD-1:0];
                     cmd_valid <= 1'b1;
                  end else if (state == DATA && bit_cnt == CNT_DATA) begin
                     data_word  <= rx_shift;
                     data_valid <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end else if ((state == CMD) ? !csd_s : !csc_s) begin
                  // The other select joined mid-frame. The frame is
                  // discarded, and the error is reported once both are released.
                  state <= ERR;
               end else if (scl_rise) begin
                  rx_shift <= {rx_shift[WIDTH_DATA-2:0], sdi_s};
                  if (bit_cnt != CNT_MAX) begin
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
                  // The master sampled sdo at this edge, so advance to the next bit.
                  if (state == DATA) begin
                     tx_shift <= {tx_shift[WIDTH_DATA-2:0], 1'b0};
                  end
               end
            end

            ERR: begin
               if (both_idle) begin
                  state     <= IDLE;
                  frame_err <= 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_slave_frontend.sv
// tb/tb_spi_slave_frontend.sv - directed and randomised bench for spi_slave_frontend

module tb_spi_slave_frontend;

   localparam int WC = 8;
   localparam int WD = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        spi_scl;
   logic        spi_sdi;
   logic        spi_cs_cmd;
   logic        spi_cs_data;
   logic        spi_sdo;
   logic [15:0] tx_data;
   logic        cmd_valid;
   logic [7:0]  cmd_word;
   logic        data_valid;
   logic [15:0] data_word;
   logic        frame_err;

   int vectors     = 0;
   int miscompares = 0;

   // Pulse counters observed from the DUT.
   int n_cmd  = 0;
   int n_data = 0;
   int n_err  = 0;

   // Reference model state.
   logic [7:0]  exp_cmd;
   logic [15:0] exp_data;
   int exp_ncmd  = 0;
   int exp_ndata = 0;
   int exp_nerr  = 0;

   always #10 clk = ~clk;

   spi_slave_frontend #(
      .WIDTH_CMD   (WC),
      .WIDTH_DATA  (WD),
      .SYNC_STAGES (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .spi_scl     (spi_scl),
      .spi_sdi     (spi_sdi),
      .spi_cs_cmd  (spi_cs_cmd),
      .spi_cs_data (spi_cs_data),
      .spi_sdo     (spi_sdo),
      .tx_data     (tx_data),
      .cmd_valid   (cmd_valid),
      .cmd_word    (cmd_word),
      .data_valid  (data_valid),
      .data_word   (data_word),
      .frame_err   (frame_err)
   );

   always @(posedge clk) begin
      #1;
      if (cmd_valid === 1'b1)  n_cmd++;
      if (data_valid === 1'b1) n_data++;
      if (frame_err === 1'b1)  n_err++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] counts(input int c, input int d, input int e);
      return 32'((c << 20) + (d << 10) + e);
   endfunction

   // SCL half-period of 5 clk (100 ns).
   task automatic half();
      repeat (5) @(negedge clk);
   endtask

   task automatic clock_bit(input logic b, inout logic [31:0] cap);
      spi_sdi = b;
      half();
      spi_scl = 1'b1;
      cap = {cap[30:0], spi_sdo};
      half();
      spi_scl = 1'b0;
   endtask

   // Releases both selects and checks pulse timing, pulse type and words.
   task automatic finish_frame(input string tag, input logic [2:0] pat);
      spi_cs_cmd  = 1'b1;
      spi_cs_data = 1'b1;
      repeat (2) @(negedge clk);
      check({tag, " early"}, {29'd0, cmd_valid, data_valid, frame_err}, 32'd0);
      @(negedge clk);
      check({tag, " pulse"}, {29'd0, cmd_valid, data_valid, frame_err}, {29'd0, pat});
      @(negedge clk);
      check({tag, " width"}, {29'd0, cmd_valid, data_valid, frame_err}, 32'd0);
      repeat (3) @(negedge clk);
      check({tag, " counts"}, counts(n_cmd, n_data, n_err), counts(exp_ncmd, exp_ndata, exp_nerr));
      check({tag, " cmd_word"}, {24'd0, cmd_word}, {24'd0, exp_cmd});
      check({tag, " data_word"}, {16'd0, data_word}, {16'd0, exp_data});
   endtask

   task automatic do_frame(input logic is_cmd, input int nbits, input logic [31:0] word,
                           input logic [15:0] txw, input string tag);
      logic [31:0] cap;
      logic [31:0] exp_cap;
      logic [31:0] full;
      logic [2:0]  pat;
      cap = '0;
      tx_data = txw;
      @(negedge clk);
      if (is_cmd) spi_cs_cmd = 1'b0;
      else        spi_cs_data = 1'b0;
      for (int i = nbits - 1; i >= 0; i--) begin
         clock_bit(word[i], cap);
         // Mid-frame changes to tx_data must not reach sdo in a data frame.
         if (!is_cmd) tx_data = ~txw;
      end
      half();
      if (is_cmd && nbits == WC) begin
         exp_cmd = word[7:0];
         exp_ncmd++;
         pat = 3'b100;
      end else if (!is_cmd && nbits == WD) begin
         exp_data = word[15:0];
         exp_ndata++;
         pat = 3'b010;
      end else begin
         exp_nerr++;
         pat = 3'b001;
      end
      if (is_cmd) begin
         exp_cap = txw[15] ? ((32'd1 << nbits) - 32'd1) : 32'd0;
      end else begin
         full    = {txw, 16'h0000};
         exp_cap = full >> (32 - nbits);
      end
      finish_frame(tag, pat);
      check({tag, " sdo"}, cap, exp_cap);
      tx_data = txw;
   endtask

   initial begin
      logic [31:0] cap;
      logic [31:0] word;
      int          len;
      int          r;
      logic        kind;

      rst_n       = 1'b0;
      spi_scl     = 1'b0;
      spi_sdi     = 1'b0;
      spi_cs_cmd  = 1'b1;
      spi_cs_data = 1'b1;
      tx_data     = 16'hFFFF;
      exp_cmd     = 8'h00;
      exp_data    = 16'h0000;

      repeat (3) @(negedge clk);
      check("reset pulses", {28'd0, cmd_valid, data_valid, frame_err, spi_sdo}, 32'd0);
      check("reset cmd_word", {24'd0, cmd_word}, 32'd0);
      check("reset data_word", {16'd0, data_word}, 32'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("post-reset counts", counts(n_cmd, n_data, n_err), 32'd0);

      do_frame(1'b1, 8, 32'h80, 16'h1234, "cmd80");
      do_frame(1'b0, 16, 32'hA5C3, 16'h0F0F, "dataA5C3");
      do_frame(1'b1, 8, 32'h01, 16'h8001, "cmd01");
      do_frame(1'b0, 16, 32'hFFFF, 16'h5A5A, "dataFFFF");

      do_frame(1'b0, 16, $urandom, 16'h1234, "read1234");
      do_frame(1'b0, 16, $urandom, 16'hFFFF, "readFFFF");
      do_frame(1'b0, 16, $urandom, 16'h0001, "read0001");

      do_frame(1'b1, 7, 32'h55, 16'h0000, "short cmd");
      do_frame(1'b0, 17, 32'h1BEEF, 16'hC001, "long data");

      // Both selects low: error only after both are released.
      cap = '0;
      word = 32'hC3;
      @(negedge clk);
      spi_cs_cmd = 1'b0;
      for (int i = 7; i >= 5; i--) clock_bit(word[i], cap);
      spi_cs_data = 1'b0;
      for (int i = 4; i >= 0; i--) clock_bit(word[i], cap);
      half();
      spi_cs_cmd = 1'b0;
      spi_cs_cmd = 1'b1;
      repeat (8) @(negedge clk);
      check("both-cs held", counts(n_cmd, n_data, n_err), counts(exp_ncmd, exp_ndata, exp_nerr));
      exp_nerr++;
      finish_frame("both-cs", 3'b001);
      do_frame(1'b1, 8, 32'h3C, 16'h7777, "after both-cs");

      // Reset in the middle of a data frame.
      cap = '0;
      word = 32'h0000_A000;
      tx_data = 16'hBEEF;
      @(negedge clk);
      spi_cs_data = 1'b0;
      for (int i = 15; i >= 11; i--) clock_bit(word[i], cap);
      #3 rst_n = 1'b0;
      #1;
      check("mid-reset pulses", {28'd0, cmd_valid, data_valid, frame_err, spi_sdo}, 32'd0);
      check("mid-reset cmd_word", {24'd0, cmd_word}, 32'd0);
      check("mid-reset data_word", {16'd0, data_word}, 32'd0);
      exp_cmd  = 8'h00;
      exp_data = 16'h0000;
      spi_cs_data = 1'b1;
      spi_scl     = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("post mid-reset counts", counts(n_cmd, n_data, n_err), counts(exp_ncmd, exp_ndata, exp_nerr));
      do_frame(1'b0, 16, 32'h00FF, 16'h2468, "data00FF");

      // Randomised frames, occasionally one bit short or long.
      for (int k = 0; k < 16; k++) begin
         kind = 1'($urandom_range(0, 1));
         len  = kind ? WC : WD;
         r    = int'($urandom_range(0, 5));
         if (r == 0)      len = len - 1;
         else if (r == 1) len = len + 1;
         do_frame(kind, len, $urandom, 16'($urandom), $sformatf("rand%0d", k));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
